// File: rtl/cpu24_pkg.sv
// Constants shared across the CPU24 datapath blocks.
package cpu24_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/arb_mux_n_rr_grant.sv
// Rotating priority encoder: grants the first requester at or above ptr, wrapping at N_IN.
module rr_grant #(
    parameter  int N_IN = 4,
    localparam int SELW = $clog2(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (!gnt_vld && req[(int'(ptr) + k) % N_IN]) begin
                gnt_vld = 1'b1;
                gnt_idx = SELW'((int'(ptr) + k) % N_IN);
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N:1 selector with a single registered output stage; fixed-select or round-robin grant,
// valid/ready on both sides.
module arb_mux_n
    import cpu24_pkg::*;
#(
    parameter  int N_IN = 4,
    parameter  int DW   = 5,
    localparam int SELW = $clog2(N_IN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N_IN*DW-1:0] in_data,
    input  logic [N_IN-1:0]    in_valid,
    output logic [N_IN-1:0]    in_ready,
    output logic [DW-1:0]      out_data,
    output logic [SELW-1:0]    out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [DW-1:0]   w_ch [N_IN];
    logic            w_load_en;
    logic            w_sel_ok;
    logic            w_fix_vld;
    logic [SELW-1:0] w_rr_idx;
    logic            w_rr_vld;
    logic [SELW-1:0] w_gnt_idx;
    logic            w_gnt_vld;
    logic            w_accept;
    logic [SELW-1:0] w_ptr_nxt;

    logic [DW-1:0]   r_out_data;
    logic [SELW-1:0] r_out_src;
    logic            r_out_valid;
    logic [SELW-1:0] r_ptr;

    for (genvar g = 0; g < N_IN; g++) begin : g_ch
        assign w_ch[g] = in_data[g*DW +: DW];
    end

    rr_grant #(.N_IN(N_IN)) u_rr_grant (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_rr_idx),
        .gnt_vld (w_rr_vld)
    );

    // sel beyond the last channel (non-power-of-2 N_IN) simply yields no grant
    assign w_sel_ok  = int'(sel) < N_IN;
    assign w_fix_vld = w_sel_ok && in_valid[sel];

    assign w_gnt_vld = (mode == MODE_FIXED) ? w_fix_vld : w_rr_vld;
    assign w_gnt_idx = (mode == MODE_FIXED) ? sel : w_rr_idx;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_accept  = w_load_en && w_gnt_vld;
    assign w_ptr_nxt = (int'(w_gnt_idx) == N_IN - 1) ? '0 : w_gnt_idx + SELW'(1);

    always_comb begin
        in_ready = '0;
        if (w_accept) in_ready[w_gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_gnt_vld) begin
                r_out_data  <= w_ch[w_gnt_idx];
                r_out_src   <= w_gnt_idx;
                r_out_valid <= 1'b1;
                if (mode == MODE_RR) r_ptr <= w_ptr_nxt;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule
